// File: rtl/cpu_jmp_pkg.sv
// Shared definitions for the jump/branch address unit: jump mode encodings
// and the reserved-mode check used by the top level.
package cpu_jmp_pkg;

    typedef enum logic [2:0] {
        MODE_SEQ  = 3'b000,
        MODE_BASE = 3'b001,
        MODE_ABS  = 3'b010,
        MODE_REL  = 3'b011,
        MODE_CALL = 3'b100,
        MODE_RET  = 3'b101
    } jmp_mode_e;

    // Encodings 110 and 111 are not assigned to any jump mode.
    function automatic logic is_reserved_mode(input logic [2:0] mode);
        return (mode > 3'(MODE_RET));
    endfunction

endpackage

// File: rtl/cpu_jmp_lifo.sv
// Return-address LIFO for the jump unit. The pointer counts 0..DEPTH and
// always names the next free slot. A push while full and a pop while empty
// are ignored here; the caller decides how to flag them. FULL and EMPTY are
// registered and track the post-edge occupancy.
module cpu_jmp_lifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] TOP,
    output logic             FULL,
    output logic             EMPTY
);

    localparam int unsigned PW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] w_top;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = PUSH & ~r_full;
    assign w_do_pop  = POP & ~r_empty;

    // Select the most recently pushed entry (zero when the stack is empty).
    always_comb begin
        w_top = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_ptr == PW'(i + 1)) begin
                w_top = r_mem[i];
            end else begin
                w_top = w_top;
            end
        end
    end

    // Pointer, occupancy flags and entry storage update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_ptr == PW'(i)) begin
                    r_mem[i] <= DIN;
                end
            end
            r_ptr   <= r_ptr + PW'(1);
            r_full  <= (r_ptr + PW'(1)) == PW'(DEPTH);
            r_empty <= 1'b0;
        end else if (w_do_pop) begin
            r_ptr   <= r_ptr - PW'(1);
            r_full  <= 1'b0;
            r_empty <= (r_ptr == PW'(1));
        end
    end

    assign TOP   = w_top;
    assign FULL  = r_full;
    assign EMPTY = r_empty;

endmodule

// File: rtl/cpu_jmp_stack.sv
// Next-PC generator for the one-cycle CPU. Forms ADDRESS_OUT from PC, the
// base register, OFFSET and the return-address store, and keeps a sticky
// error flag.
// Optional feature macro: CPU_JMP_CALL_STACK_EN selects a DEPTH-entry return
// LIFO; without it a single link register holds the return address.
module cpu_jmp_stack
    import cpu_jmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             JMP_EN,
    input  logic [2:0]       JMP_MODE,
    input  logic [WIDTH-1:0] OFFSET,
    input  logic             BASE_REG_LD,
    input  logic [WIDTH-1:0] BASE_REG_DATA,
    input  logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] ADDRESS_OUT,
    output logic             JMP_TAKEN,
    output logic             STACK_FULL,
    output logic             STACK_EMPTY,
    output logic             STACK_ERR
);

    logic [WIDTH-1:0] r_base;
    logic             r_err;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_base_tgt;
    logic [WIDTH-1:0] w_addr;
    logic             w_taken;
    logic             w_push;
    logic             w_pop;
    logic             w_err_set;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;

    assign w_seq      = PC + WIDTH'(1);
    assign w_base_tgt = r_base + OFFSET;

`ifdef CPU_JMP_CALL_STACK_EN
    cpu_jmp_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (w_push),
        .POP   (w_pop),
        .DIN   (w_seq),
        .TOP   (w_top),
        .FULL  (w_full),
        .EMPTY (w_empty)
    );
`else
    logic [WIDTH-1:0] r_link;

    // Single link register: every CALL overwrites it with the return address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_link <= '0;
        end else if (w_push) begin
            r_link <= w_seq;
        end
    end

    assign w_top   = r_link;
    assign w_full  = 1'b0;
    assign w_empty = 1'b0;
`endif

    // Next-address mux, taken flag, stack requests and error detection.
    always_comb begin
        w_addr    = w_seq;
        w_taken   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (JMP_EN) begin
            case (JMP_MODE)
                MODE_SEQ: begin
                    w_addr = w_seq;
                end
                MODE_BASE: begin
                    w_addr  = w_base_tgt;
                    w_taken = 1'b1;
                end
                MODE_ABS: begin
                    w_addr  = OFFSET;
                    w_taken = 1'b1;
                end
                MODE_REL: begin
                    // Two's-complement add equals PC + signed displacement mod 2^WIDTH.
                    w_addr  = PC + OFFSET;
                    w_taken = 1'b1;
                end
                MODE_CALL: begin
                    w_addr  = w_base_tgt;
                    w_taken = 1'b1;
                    if (w_full) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                MODE_RET: begin
                    if (w_empty) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_addr  = w_top;
                        w_taken = 1'b1;
                        w_pop   = 1'b1;
                    end
                end
                default: begin
                    w_err_set = is_reserved_mode(JMP_MODE);
                end
            endcase
        end else begin
            w_addr = w_seq;
        end
    end

    // Base register load; a same-cycle BASE/CALL still sees the old value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_base <= '0;
        end else if (BASE_REG_LD) begin
            r_base <= BASE_REG_DATA;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_err_set;
        end
    end

    assign ADDRESS_OUT = w_addr;
    assign JMP_TAKEN   = w_taken;
    assign STACK_FULL  = w_full;
    assign STACK_EMPTY = w_empty;
    assign STACK_ERR   = r_err;

endmodule

// File: tb/tb_cpu_jmp_stack.sv
// Directed bench for cpu_jmp_stack (WIDTH=8, DEPTH=4). Expectations follow
// whichever return-address store the build selects.
module tb_cpu_jmp_stack;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         jmp_en;
    logic [2:0]   jmp_mode;
    logic [W-1:0] offset;
    logic         base_ld;
    logic [W-1:0] base_data;
    logic [W-1:0] pc;
    logic [W-1:0] addr_out;
    logic         taken;
    logic         full;
    logic         empty;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CPU_JMP_CALL_STACK_EN
    localparam logic STACK_MODE = 1'b1;
`else
    localparam logic STACK_MODE = 1'b0;
`endif

    cpu_jmp_stack #(.WIDTH(W), .DEPTH(4)) dut (
        .CLK           (clk),
        .RST           (rst),
        .JMP_EN        (jmp_en),
        .JMP_MODE      (jmp_mode),
        .OFFSET        (offset),
        .BASE_REG_LD   (base_ld),
        .BASE_REG_DATA (base_data),
        .PC            (pc),
        .ADDRESS_OUT   (addr_out),
        .JMP_TAKEN     (taken),
        .STACK_FULL    (full),
        .STACK_EMPTY   (empty),
        .STACK_ERR     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] off;
        logic [W-1:0] pc;
        logic [W-1:0] exp_addr;
        logic         exp_taken;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, then let combinational settle.
    task automatic drive(input logic r, input logic en, input logic [2:0] m,
                         input logic [W-1:0] off, input logic [W-1:0] p,
                         input logic ld, input logic [W-1:0] ldd);
        @(negedge clk);
        rst = r; jmp_en = en; jmp_mode = m; offset = off; pc = p;
        base_ld = ld; base_data = ldd;
        #1;
    endtask

    // Wait for the edge ending the current cycle and settle past it.
    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'b000, 8'h00, 8'h10, 8'h11, 1'b0};
        vecs[1] = '{1'b1, 3'b011, 8'hFC, 8'h05, 8'h01, 1'b1};
        vecs[2] = '{1'b1, 3'b011, 8'h02, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{1'b1, 3'b010, 8'hC3, 8'h10, 8'hC3, 1'b1};
        vecs[4] = '{1'b1, 3'b001, 8'h44, 8'h10, 8'h44, 1'b1};
        vecs[5] = '{1'b0, 3'b010, 8'hC3, 8'h33, 8'h34, 1'b0};
        vecs[6] = '{1'b1, 3'b000, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 3'b011, 8'h7F, 8'h80, 8'hFF, 1'b1};

        rst = 1'b1; jmp_en = 1'b0; jmp_mode = 3'b000; offset = '0; pc = '0;
        base_ld = 1'b0; base_data = '0;
        repeat (2) @(posedge clk);

        // Reset state and first SEQ.
        drive(1'b0, 1'b1, 3'b000, 8'h00, 8'h10, 1'b0, 8'h00);
        check("reset_empty", {31'd0, empty}, {31'd0, STACK_MODE});
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("seq_addr", {24'd0, addr_out}, 32'h11);
        check("seq_taken", {31'd0, taken}, 32'd0);
        finish_cycle();

        // Stateless modes from the vector table (base is still 0).
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vecs[i].en, vecs[i].mode, vecs[i].off, vecs[i].pc, 1'b0, 8'h00);
            check($sformatf("vec%0d_addr", i), {24'd0, addr_out}, {24'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_taken", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
            finish_cycle();
        end

        // Base load with a same-cycle BASE uses the old base.
        drive(1'b0, 1'b1, 3'b001, 8'hA7, 8'h00, 1'b1, 8'h0A);
        check("base_old", {24'd0, addr_out}, 32'hA7);
        finish_cycle();
        drive(1'b0, 1'b1, 3'b001, 8'hA7, 8'h00, 1'b0, 8'h0A);
        check("base_new", {24'd0, addr_out}, 32'hB1);
        finish_cycle();

        // Four CALLs to base+0x30 = 0x3A.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 3'b100, 8'h30, 8'h20 + W'(i), 1'b0, 8'h00);
            check($sformatf("call%0d_addr", i), {24'd0, addr_out}, 32'h3A);
            check($sformatf("call%0d_taken", i), {31'd0, taken}, 32'd1);
            finish_cycle();
        end
        check("full_after4", {31'd0, full}, {31'd0, STACK_MODE});
        check("err_after4", {31'd0, err}, 32'd0);

        // Fifth CALL: still jumps; overflows the LIFO, or overwrites the link.
        drive(1'b0, 1'b1, 3'b100, 8'h30, 8'h24, 1'b0, 8'h00);
        check("call5_addr", {24'd0, addr_out}, 32'h3A);
        check("call5_taken", {31'd0, taken}, 32'd1);
        finish_cycle();
        check("call5_err", {31'd0, err}, {31'd0, STACK_MODE});

        // Four RETs.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 3'b101, 8'h00, 8'h50, 1'b0, 8'h00);
            check($sformatf("ret%0d_addr", i), {24'd0, addr_out},
                  STACK_MODE ? 32'h24 - 32'(i) : 32'h25);
            check($sformatf("ret%0d_taken", i), {31'd0, taken}, 32'd1);
            finish_cycle();
        end
        check("empty_after_rets", {31'd0, empty}, {31'd0, STACK_MODE});

        // Fifth RET: underflow on the LIFO, link still valid otherwise.
        drive(1'b0, 1'b1, 3'b101, 8'h00, 8'h50, 1'b0, 8'h00);
        check("ret5_addr", {24'd0, addr_out}, STACK_MODE ? 32'h51 : 32'h25);
        check("ret5_taken", {31'd0, taken}, {31'd0, ~STACK_MODE});
        finish_cycle();

        // Disabled CALL: sequential, no push.
        drive(1'b0, 1'b0, 3'b100, 8'h30, 8'h40, 1'b0, 8'h00);
        check("dis_call_addr", {24'd0, addr_out}, 32'h41);
        check("dis_call_taken", {31'd0, taken}, 32'd0);
        finish_cycle();
        drive(1'b0, 1'b1, 3'b101, 8'h00, 8'h45, 1'b0, 8'h00);
        check("dis_call_ret", {24'd0, addr_out}, STACK_MODE ? 32'h46 : 32'h25);
        finish_cycle();
        check("err_before_rsv", {31'd0, err}, {31'd0, STACK_MODE});

        // Reserved mode: sequential, sets sticky error.
        drive(1'b0, 1'b1, 3'b110, 8'h12, 8'h60, 1'b0, 8'h00);
        check("rsv_addr", {24'd0, addr_out}, 32'h61);
        check("rsv_taken", {31'd0, taken}, 32'd0);
        finish_cycle();
        check("rsv_err", {31'd0, err}, 32'd1);
        drive(1'b0, 1'b1, 3'b000, 8'h00, 8'h61, 1'b0, 8'h00);
        finish_cycle();
        check("rsv_err_sticky", {31'd0, err}, 32'd1);

        // Two CALLs then RST: stack and error cleared, RET falls through.
        drive(1'b0, 1'b1, 3'b100, 8'h30, 8'h70, 1'b0, 8'h00);
        finish_cycle();
        drive(1'b0, 1'b1, 3'b100, 8'h30, 8'h71, 1'b0, 8'h00);
        finish_cycle();
        check("pre_rst_empty", {31'd0, empty}, 32'd0);
        drive(1'b1, 1'b1, 3'b101, 8'h00, 8'h72, 1'b0, 8'h00);
        check("rst_comb_ret", {24'd0, addr_out}, STACK_MODE ? 32'h72 : 32'h72);
        finish_cycle();
        check("post_rst_empty", {31'd0, empty}, {31'd0, STACK_MODE});
        check("post_rst_err", {31'd0, err}, 32'd0);
        drive(1'b0, 1'b1, 3'b101, 8'h00, 8'h80, 1'b0, 8'h00);
        check("post_rst_ret_addr", {24'd0, addr_out}, STACK_MODE ? 32'h81 : 32'h00);
        check("post_rst_ret_taken", {31'd0, taken}, {31'd0, ~STACK_MODE});
        finish_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
